// File: rtl/fill_row_engine.sv
// fill_row_engine: scanline fill datapath between the fill controller,
// the edge table and the framebuffer write port.
module fill_row_engine #(
    parameter int X_W  = 10,
    parameter int Y_W  = 9,
    parameter int COLS = 640,
    parameter int C_W  = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load,
    input  logic [Y_W-1:0]   y_min,
    input  logic [Y_W-1:0]   y_max,
    input  logic [C_W-1:0]   color,
    input  logic             row_start,
    input  logic             fill_start,
    output logic             row_done,
    output logic             fill_done,
    output logic             all_finish,
    output logic             edge_rd,
    output logic [Y_W-1:0]   edge_addr,
    input  logic             edge_valid,
    input  logic [2*X_W:0]   edge_rdata,
    output logic             px_wr,
    output logic [X_W-1:0]   px_x,
    output logic [Y_W-1:0]   px_y,
    output logic [C_W-1:0]   px_color,
    input  logic             px_ready
);

    localparam logic [X_W-1:0] X_MAX = X_W'(COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_ROW_DONE,
        S_ARMED,
        S_FILL,
        S_FILL_DONE,
        S_FINISHED
    } state_t;

    state_t state_q, state_d;

    logic [Y_W-1:0] cur_y_q, cur_y_d;
    logic [Y_W-1:0] y_max_q, y_max_d;
    logic [C_W-1:0] color_q, color_d;
    logic [X_W-1:0] x_l_q, x_l_d;
    logic [X_W-1:0] x_r_q, x_r_d;
    logic           empty_q, empty_d;

    logic           row_done_q, row_done_d;
    logic           fill_done_q, fill_done_d;
    logic           all_finish_q, all_finish_d;
    logic           edge_rd_q, edge_rd_d;
    logic [Y_W-1:0] edge_addr_q, edge_addr_d;
    logic           px_wr_q, px_wr_d;
    logic [X_W-1:0] px_x_q, px_x_d;
    logic [Y_W-1:0] px_y_q, px_y_d;
    logic [C_W-1:0] px_color_q, px_color_d;

    logic           edge_empty;
    logic [X_W-1:0] edge_xa;
    logic [X_W-1:0] edge_xb;
    logic [X_W-1:0] edge_lo;
    logic [X_W-1:0] edge_hi;
    logic           row_end;

    assign edge_empty = edge_rdata[2*X_W];
    assign edge_xa    = edge_rdata[2*X_W-1:X_W];
    assign edge_xb    = edge_rdata[X_W-1:0];

    // Order the two crossings and clamp both into the framebuffer.
    always_comb begin
        edge_lo = (edge_xa < edge_xb) ? edge_xa : edge_xb;
        edge_hi = (edge_xa < edge_xb) ? edge_xb : edge_xa;
        if (edge_lo > X_MAX) begin
            edge_lo = X_MAX;
        end
        if (edge_hi > X_MAX) begin
            edge_hi = X_MAX;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d      = state_q;
        cur_y_d      = cur_y_q;
        y_max_d      = y_max_q;
        color_d      = color_q;
        x_l_d        = x_l_q;
        x_r_d        = x_r_q;
        empty_d      = empty_q;
        all_finish_d = all_finish_q;
        edge_addr_d  = edge_addr_q;
        px_x_d       = px_x_q;
        px_y_d       = px_y_q;
        px_color_d   = px_color_q;
        row_done_d   = 1'b0;
        fill_done_d  = 1'b0;
        edge_rd_d    = 1'b0;
        px_wr_d      = 1'b0;
        row_end      = 1'b0;

        if (load) begin
            cur_y_d      = y_min;
            y_max_d      = y_max;
            color_d      = color;
            all_finish_d = (y_min > y_max);
            state_d      = (y_min > y_max) ? S_FINISHED : S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (row_start && !all_finish_q) begin
                        state_d     = S_RD_REQ;
                        edge_rd_d   = 1'b1;
                        edge_addr_d = cur_y_q;
                    end
                end
                S_RD_REQ: begin
                    state_d = S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (edge_valid) begin
                        x_l_d      = edge_lo;
                        x_r_d      = edge_hi;
                        empty_d    = edge_empty;
                        row_done_d = 1'b1;
                        state_d    = S_ROW_DONE;
                    end
                end
                S_ROW_DONE: begin
                    state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (fill_start) begin
                        if (empty_q) begin
                            row_end = 1'b1;
                        end else begin
                            state_d    = S_FILL;
                            px_wr_d    = 1'b1;
                            px_x_d     = x_l_q;
                            px_y_d     = cur_y_q;
                            px_color_d = color_q;
                        end
                    end
                end
                S_FILL: begin
                    px_wr_d = 1'b1;
                    if (px_ready) begin
                        if (px_x_q == x_r_q) begin
                            row_end = 1'b1;
                        end else begin
                            px_x_d = px_x_q + X_W'(1);
                        end
                    end
                end
                S_FILL_DONE: begin
                    state_d = all_finish_q ? S_FINISHED : S_IDLE;
                end
                S_FINISHED: begin
                    state_d = S_FINISHED;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (row_end) begin
                state_d      = S_FILL_DONE;
                px_wr_d      = 1'b0;
                fill_done_d  = 1'b1;
                cur_y_d      = cur_y_q + Y_W'(1);
                all_finish_d = (cur_y_q == y_max_q);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Row context and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cur_y_q      <= '0;
            y_max_q      <= '0;
            color_q      <= '0;
            x_l_q        <= '0;
            x_r_q        <= '0;
            empty_q      <= 1'b0;
            row_done_q   <= 1'b0;
            fill_done_q  <= 1'b0;
            all_finish_q <= 1'b0;
            edge_rd_q    <= 1'b0;
            edge_addr_q  <= '0;
            px_wr_q      <= 1'b0;
            px_x_q       <= '0;
            px_y_q       <= '0;
            px_color_q   <= '0;
        end else begin
            cur_y_q      <= cur_y_d;
            y_max_q      <= y_max_d;
            color_q      <= color_d;
            x_l_q        <= x_l_d;
            x_r_q        <= x_r_d;
            empty_q      <= empty_d;
            row_done_q   <= row_done_d;
            fill_done_q  <= fill_done_d;
            all_finish_q <= all_finish_d;
            edge_rd_q    <= edge_rd_d;
            edge_addr_q  <= edge_addr_d;
            px_wr_q      <= px_wr_d;
            px_x_q       <= px_x_d;
            px_y_q       <= px_y_d;
            px_color_q   <= px_color_d;
        end
    end

    assign row_done   = row_done_q;
    assign fill_done  = fill_done_q;
    assign all_finish = all_finish_q;
    assign edge_rd    = edge_rd_q;
    assign edge_addr  = edge_addr_q;
    assign px_wr      = px_wr_q;
    assign px_x       = px_x_q;
    assign px_y       = px_y_q;
    assign px_color   = px_color_q;

endmodule

// File: doc/fill_row_engine.md
# fill_row_engine

Scanline fill datapath that answers the fill controller's row/fill handshake. On `row_start` it fetches the current row's left/right edge crossings from the edge table and pulses `row_done`. On `fill_start` it streams one pixel write per pixel between the crossings into the framebuffer write port, then pulses `fill_done` and advances to the next row. It raises `all_finish` once every row from `y_min` to `y_max` has been filled. It sits between the fill controller, the math stage's edge table and the framebuffer arbiter.

## Interface
- `X_W`, default 10: x coordinate width.
- `Y_W`, default 9: y coordinate width.
- `COLS`, default 640: framebuffer width; x clamped to `COLS-1`.
- `C_W`, default 8: pixel colour width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `load`  in  1  one-cycle pulse (driven from `math_done`); samples `y_min`, `y_max`, `color`.
- `y_min`, `y_max`  in  `Y_W`  first and last row to fill.
- `color`  in  `C_W`  fill colour.
- `row_start`  in  1  level from controller: fetch current row.
- `fill_start`  in  1  level from controller: fill current row.
- `row_done`  out  1  one-cycle pulse: row edges latched.
- `fill_done`  out  1  one-cycle pulse: row fully written.
- `all_finish`  out  1  level: no rows remain.
- `edge_rd`  out  1  one-cycle edge-table read request.
- `edge_addr`  out  `Y_W`  row address (current y).
- `edge_valid`  in  1  read data valid; one or more cycles after `edge_rd`.
- `edge_rdata`  in  `2*X_W+1`  {empty, x_a, x_b}; empty=1 means the row has no crossings.
- `px_wr`  out  1  pixel write request.
- `px_x`  out  `X_W`; `px_y`  out  `Y_W`; `px_color`  out  `C_W`  write data.
- `px_ready`  in  1  write accepted when `px_wr & px_ready`.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, ROW_DONE, ARMED, FILL, FILL_DONE, FINISHED.
- IDLE: on `row_start` with `all_finish`=0, go to RD_REQ. `fill_start` is ignored here.
- RD_REQ: assert `edge_rd` with `edge_addr`=cur_y for one cycle, then go to RD_WAIT.
- RD_WAIT: on `edge_valid`, latch x_l=min(x_a,x_b) and x_r=max(x_a,x_b), each clamped to `COLS-1`. Latch the empty flag. Go to ROW_DONE.
- ROW_DONE: `row_done`=1 for one cycle, then go to ARMED unconditionally. `row_start` still being high does not retrigger a fetch.
- ARMED: on `fill_start`, go to FILL with x=x_l. If empty=1, go directly to FILL_DONE.
- FILL: `px_wr`=1, `px_x`=x, `px_y`=cur_y, `px_color`=colour. The outputs hold stable until accepted. On accept, if x==x_r go to FILL_DONE, else x++.
- FILL_DONE: `fill_done`=1 for one cycle. On the same edge cur_y++, and `all_finish` is set if cur_y==y_max (new y > y_max). Next state is FINISHED if finished, else IDLE.
- FINISHED: `all_finish` is held at 1. `row_start` and `fill_start` are ignored.
- `load`, from any state: cur_y←y_min and latch `color`. `all_finish`←(y_min>y_max). Go to FINISHED if that comparison is true, else IDLE. Any in-flight read or fill is abandoned and `px_wr` drops the next cycle.
- Widths: the cur_y compare is unsigned at `Y_W`. x runs in `X_W` and cannot wrap because x_r ≤ `COLS-1`.

## Timing
- Reset values: every output is 0 (`row_done`, `fill_done`, `all_finish`, `edge_rd`, `px_wr`, all address/data buses). State is IDLE and cur_y=0.
- All outputs are registered. Reset mid-operation aborts immediately with no completion pulse.
- Fetch latency: `row_start` seen at cycle 0 → `edge_rd` at 1 → `edge_valid` at ≥2 (cycle v) → `row_done` at v+1.
- Fill latency: `fill_start` seen at cycle 0 → first `px_wr` at 1. With `px_ready` high, there is one pixel per cycle. `fill_done` comes the cycle after the last accept. An empty row gives `fill_done` at cycle 1.
- `all_finish` is valid in the same cycle as `fill_done`, so the controller sees it on its next READROW cycle.
- If `load` and `edge_valid` coincide, `load` wins.

## Test plan
- `y_min`=5, `y_max`=5, edges {0,10,13}, `px_ready`=1 → `edge_addr`=5; writes at x=10,11,12,13 with y=5 on 4 consecutive cycles; `fill_done` the next cycle with `all_finish`=1 in the same cycle.
- Edges {0,13,10} (swapped) → identical writes to x=10..13.
- Empty row {1,x,x} → no `px_wr`; `fill_done` 1 cycle after `fill_start`.
- `px_ready` toggled 1,0,0,1 during the fill → `px_x` holds during stalls; exactly x_r−x_l+1 writes, with no duplicates.
- x_b=1000, `COLS`=640 → last write at x=639. `y_min`=7, `y_max`=3 → `all_finish`=1 one cycle after `load`, and no reads are issued.
- `n_rst` low mid-fill, then `load` mid-fill → all outputs 0 during reset; after `load`, `px_wr` drops and a fresh sequence starts at the new `y_min`.
